tff_down_counter: RTL
=====================

Name: tff_down_counter

Overview:
- Synchronous, loadable, parameterised-width down counter with terminal-count pulse and optional auto-reload. It is the counting-down counterpart of the team's T-flip-flop up counters.
- Used as a programmable interval timer and event down-counter alongside the existing up-counter blocks.
- Count path is built as a synchronous T-toggle chain: bit i toggles when count-enabled and all lower bits are 0. No ripple clocking; every flop is clocked by clock.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2 to 16).

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising clock edge.
- load  input  1  load strobe; Q and the reload register take load_val.
- load_val  input  WIDTH  start and reload value.
- enable  input  1  count enable; when 0, the block holds its state.
- auto_reload  input  1  1 = restart from the reload value after reaching 0; 0 = stop at 0.
- Q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- busy  output  1  high while in state RUN, registered.

Behaviour:
- Internal state: FSM state (IDLE, RUN, DONE) and reload register rl (WIDTH bits).
- Reset (reset==0 at a clock edge): Q=0, rl=0, tc=0, busy=0, state=IDLE. Reset overrides every other input, including mid-count and mid-load.
- Priority at each edge: reset > load > enable > hold.
- tc defaults to 0 on every edge unless a rule below sets it.
- Load, any state:
  - rl<=load_val and Q<=load_val.
  - If load_val!=0: state<=RUN, busy<=1.
  - If load_val==0: state<=IDLE, busy<=0, no tc.
  - A load in the same cycle as a terminal count wins; no tc is produced for that cycle.
- IDLE and DONE: Q holds; enable is ignored; busy=0.
- RUN with enable=0: Q, rl and state hold; tc<=0.
- RUN with enable=1:
  - Q>1: Q<=Q-1.
  - Q==1: Q<=0 and tc<=1, so tc is high exactly during the first cycle Q reads 0. If auto_reload==0, state<=DONE and busy<=0; otherwise state stays RUN.
  - Q==0 (only reachable with auto_reload==1): Q<=rl, no tc.
  - If auto_reload drops to 0 while Q==0 in RUN: state<=DONE, busy<=0, Q holds 0.
- Period: in auto-reload mode the tc period is rl+1 enabled cycles. In one-shot mode tc arrives exactly load_val enabled cycles after the load edge.
- Width rules: arithmetic is modulo 2^WIDTH. Q never underflows, because the count 0 is handled explicitly above. The maximum value load_val = 2^WIDTH-1 is legal.
- Outputs are registered only; there is no combinational path from inputs to Q, tc or busy.
- Changing load_val without load has no effect; rl changes only on load.

Test Plan:
- Reset and one-shot:
  - Stimulus: hold reset=0 for 2 cycles. Release, then load=1 with load_val=3 for 1 cycle, then enable=1, auto_reload=0.
  - Required: Q=0, busy=0, tc=0 during reset. Then Q=3,2,1,0 on successive edges. tc=1 only while Q first reads 0. busy falls with that same edge. Q stays 0 and tc stays 0 thereafter.
- Auto-reload, WIDTH=4:
  - Stimulus: load_val=2, auto_reload=1, enable=1 continuously.
  - Required: Q=2,1,0,2,1,0,... with tc high every third cycle; busy stays 1.
- Enable gaps:
  - Stimulus: load_val=5, toggle enable 1,0,0,1,1.
  - Required: Q=5,4,4,4,3,2. tc stays 0.
- Load priority and zero load:
  - Load 9 while Q==1 with enable=1: Q=9, tc=0, state RUN.
  - Then load 0: Q=0, busy=0, tc never asserted.
- Full-scale and synchronous reset mid-count:
  - load_val=15: tc arrives after exactly 15 enabled cycles.
  - Separately, assert reset=0 for one edge while Q=7: Q=0, busy=0, tc=0 on that edge. The reset is sampled only at the clock edge; a reset pulse between edges has no effect.

Source files
------------

// File: rtl/tff_down_counter.sv
// Loadable down counter built from a synchronous T-toggle chain, with a
// one-cycle terminal-count pulse and optional auto-reload from a reload register.
module tff_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] r_rl;
   logic [WIDTH-1:0] w_rl_nxt;
   logic             r_tc;
   logic             w_tc_nxt;
   logic             r_busy;
   logic             w_cnt_en;
   logic [WIDTH-1:0] w_toggle;
   logic [WIDTH-1:0] w_q_dec;

   // A decrement step happens only in RUN with a non-zero count and no load.
   assign w_cnt_en = enable && !load && (r_state == RUN) && (r_q != ZERO);

   // T-toggle chain: bit i flips when counting and every lower bit is 0.
   always_comb begin
      w_toggle    = ZERO;
      w_toggle[0] = w_cnt_en;
      for (int i = 1; i < WIDTH; i++) begin
         w_toggle[i] = w_toggle[i-1] & ~r_q[i-1];
      end
      w_q_dec = r_q ^ w_toggle;
   end

   // Next-state, next-count, reload and terminal-count decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_rl_nxt    = r_rl;
      w_tc_nxt    = 1'b0;
      if (load) begin
         w_rl_nxt = load_val;
         w_q_nxt  = load_val;
         if (load_val != ZERO) begin
            w_state_nxt = RUN;
         end else begin
            w_state_nxt = IDLE;
         end
      end else begin
         case (r_state)
            RUN: begin
               if (enable) begin
                  if (r_q == ZERO) begin
                     // Count already at zero: reload, or stop if auto-reload was dropped.
                     if (auto_reload) begin
                        w_q_nxt = r_rl;
                     end else begin
                        w_state_nxt = DONE;
                     end
                  end else if (r_q == ONE) begin
                     w_q_nxt  = w_q_dec;
                     w_tc_nxt = 1'b1;
                     if (auto_reload) begin
                        w_state_nxt = RUN;
                     end else begin
                        w_state_nxt = DONE;
                     end
                  end else begin
                     w_q_nxt = w_q_dec;
                  end
               end else begin
                  w_q_nxt = r_q;
               end
            end
            IDLE: begin
               w_state_nxt = IDLE;
            end
            DONE: begin
               w_state_nxt = DONE;
            end
            default: begin
               w_state_nxt = IDLE;
               w_q_nxt     = ZERO;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= IDLE;
         r_q     <= ZERO;
         r_rl    <= ZERO;
         r_tc    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_rl    <= w_rl_nxt;
         r_tc    <= w_tc_nxt;
         r_busy  <= (w_state_nxt == RUN);
      end
   end

   assign Q    = r_q;
   assign tc   = r_tc;
   assign busy = r_busy;

endmodule
